// File: rtl/bnn_seq_interface.sv
// Start/result handshake between the image buffer front end and the BNN core.
// Optional watchdog timeout is built when BNN_IF_TIMEOUT_EN is defined.
module bnn_seq_interface #(
    parameter int IMG_W          = 30,
    parameter int IC             = 1,
    parameter int IN_BITS        = 904,
    parameter int RES_W          = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [IN_BITS-1:0]        img_in,
    input  logic                      img_buffer_full,
    input  logic                      bnn_enable,
    input  logic                      bnn_clear,
    output logic [IC*IMG_W*IMG_W-1:0] core_img,
    output logic                      core_start,
    input  logic                      core_done,
    input  logic [RES_W-1:0]          core_result,
    output logic [RES_W-1:0]          result_out,
    output logic                      result_ready,
    output logic                      busy,
    output logic                      timeout_err,
    output logic [CNT_W-1:0]          infer_count
);

    localparam int IMG_BITS = IC * IMG_W * IMG_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INFER = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [IMG_BITS-1:0]   core_img_q, core_img_d;
    logic                  core_start_q, core_start_d;
    logic [RES_W-1:0]      result_out_q, result_out_d;
    logic                  result_ready_q, result_ready_d;
    logic                  busy_q, busy_d;
    logic                  timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0]      infer_count_q, infer_count_d;
    logic                  start_s;
    logic                  wd_expired_s;

    assign start_s = img_buffer_full && bnn_enable;

    // Bits of img_in below the captured slice are intentionally dropped.
    if (IN_BITS > IMG_BITS) begin : g_low_bits
        logic unused_img_s;
        assign unused_img_s = ^img_in[IN_BITS-IMG_BITS-1:0];
    end

`ifdef BNN_IF_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_q, wd_d;

    assign wd_expired_s = (wd_q == WD_LAST);
`else
    logic unused_to_s;
    assign unused_to_s  = (TIMEOUT_CYCLES > 1);
    assign wd_expired_s = 1'b0;
`endif

    // Next-state and next-output logic for the handshake FSM.
    always_comb begin
        state_d        = state_q;
        core_img_d     = core_img_q;
        core_start_d   = 1'b0;
        result_out_d   = result_out_q;
        result_ready_d = result_ready_q;
        busy_d         = busy_q;
        timeout_err_d  = timeout_err_q;
        infer_count_d  = infer_count_q;
`ifdef BNN_IF_TIMEOUT_EN
        wd_d           = wd_q;
`endif
        case (state_q)
            ST_IDLE: begin
                result_ready_d = 1'b0;
                busy_d         = 1'b0;
                if (start_s) begin
                    core_img_d   = img_in[IN_BITS-1 -: IMG_BITS];
                    core_start_d = 1'b1;
                    busy_d       = 1'b1;
                    state_d      = ST_INFER;
`ifdef BNN_IF_TIMEOUT_EN
                    wd_d         = '0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_INFER: begin
`ifdef BNN_IF_TIMEOUT_EN
                wd_d = wd_q + {{(WD_W-1){1'b0}}, 1'b1};
`endif
                // core_done wins over the watchdog, which wins over an abort.
                if (core_done) begin
                    result_out_d   = core_result;
                    result_ready_d = 1'b1;
                    infer_count_d  = infer_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    busy_d         = 1'b0;
                    state_d        = ST_DONE;
                end else if (wd_expired_s) begin
                    result_out_d   = {RES_W{1'b1}};
                    result_ready_d = 1'b1;
                    timeout_err_d  = 1'b1;
                    busy_d         = 1'b0;
                    state_d        = ST_DONE;
                end else if (bnn_clear) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_INFER;
                end
            end
            ST_DONE: begin
                if (bnn_clear) begin
                    result_ready_d = 1'b0;
                    timeout_err_d  = 1'b0;
                    state_d        = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                result_ready_d = 1'b0;
                busy_d         = 1'b0;
                state_d        = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            core_img_q     <= '0;
            core_start_q   <= 1'b0;
            result_out_q   <= '0;
            result_ready_q <= 1'b0;
            busy_q         <= 1'b0;
            timeout_err_q  <= 1'b0;
            infer_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            core_img_q     <= core_img_d;
            core_start_q   <= core_start_d;
            result_out_q   <= result_out_d;
            result_ready_q <= result_ready_d;
            busy_q         <= busy_d;
            timeout_err_q  <= timeout_err_d;
            infer_count_q  <= infer_count_d;
        end
    end

`ifdef BNN_IF_TIMEOUT_EN
    // Watchdog counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`endif

    assign core_img     = core_img_q;
    assign core_start   = core_start_q;
    assign result_out   = result_out_q;
    assign result_ready = result_ready_q;
    assign busy         = busy_q;
    assign timeout_err  = timeout_err_q;
    assign infer_count  = infer_count_q;

endmodule

// File: tb/tb_bnn_seq_interface.sv
// Directed bench for bnn_seq_interface: default 30x30 instance plus a small 2-channel instance.
module tb_bnn_seq_interface;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [903:0] img0;
    logic         full0, en0, clr0, done0;
    logic [3:0]   res0;
    logic [899:0] core_img0;
    logic         start0, ready0, busy0, terr0;
    logic [3:0]   result0;
    logic [15:0]  cnt0;

    logic [35:0]  img1;
    logic         full1, en1, clr1, done1;
    logic [3:0]   res1;
    logic [31:0]  core_img1;
    logic         start1, ready1, busy1, terr1;
    logic [3:0]   result1;
    logic [1:0]   cnt1;

    int n_checks = 0;
    int n_pass   = 0;

    bnn_seq_interface #(
        .IMG_W(30), .IC(1), .IN_BITS(904), .RES_W(4), .TIMEOUT_CYCLES(8), .CNT_W(16)
    ) dut0 (
        .clk(clk), .rst(rst), .img_in(img0), .img_buffer_full(full0),
        .bnn_enable(en0), .bnn_clear(clr0), .core_img(core_img0),
        .core_start(start0), .core_done(done0), .core_result(res0),
        .result_out(result0), .result_ready(ready0), .busy(busy0),
        .timeout_err(terr0), .infer_count(cnt0)
    );

    bnn_seq_interface #(
        .IMG_W(4), .IC(2), .IN_BITS(36), .RES_W(4), .TIMEOUT_CYCLES(4096), .CNT_W(2)
    ) dut1 (
        .clk(clk), .rst(rst), .img_in(img1), .img_buffer_full(full1),
        .bnn_enable(en1), .bnn_clear(clr1), .core_img(core_img1),
        .core_start(start1), .core_done(done1), .core_result(res1),
        .result_out(result1), .result_ready(ready1), .busy(busy1),
        .timeout_err(terr1), .infer_count(cnt1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic chk_img0(input string tag, input logic [899:0] exp);
        for (int k = 0; k < 15; k++) begin
            chk(tag, {4'h0, core_img0[k*60 +: 60]}, {4'h0, exp[k*60 +: 60]});
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start0_pulse(input logic [903:0] img);
        img0  = img;
        full0 = 1'b1;
        en0   = 1'b1;
        step();
        full0 = 1'b0;
        en0   = 1'b0;
    endtask

    logic [899:0] pat_a, pat_b;
    logic [35:0]  vecs [5];
    logic [1:0]   ecnt [5];
    logic [35:0]  v;

    initial begin
        pat_a = {25{36'h9A5C31E7F}};
        pat_b = {25{36'h123456789}};
        vecs  = '{36'h12345678A, 36'hFEDCBA987, 36'h0F0F0F0F3, 36'hA5A5A5A5E, 36'h3C3C3C3C1};
        ecnt  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        rst = 1'b1;
        img0 = '0; full0 = 1'b0; en0 = 1'b0; clr0 = 1'b0; done0 = 1'b0; res0 = 4'h0;
        img1 = '0; full1 = 1'b0; en1 = 1'b0; clr1 = 1'b0; done1 = 1'b0; res1 = 4'h0;
        step();
        step();
        chk("rst_result", result0, 4'h0);
        chk("rst_ready", ready0, 1'b0);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_terr", terr0, 1'b0);
        chk("rst_cnt", cnt0, 16'd0);
        chk("rst_start", start0, 1'b0);
        chk_img0("rst_img", '0);
        rst = 1'b0;
        step();

        // Basic inference with junk in the low 4 bits of img_in.
        start0_pulse({pat_a, 4'h5});
        chk_img0("img_a", pat_a);
        chk("start_hi", start0, 1'b1);
        chk("busy_hi", busy0, 1'b1);
        step();
        chk("start_lo", start0, 1'b0);
        chk("busy_infer", busy0, 1'b1);
        img0 = ~{pat_a, 4'h5};
        step();
        done0 = 1'b1;
        res0  = 4'h7;
        step();
        done0 = 1'b0;
        chk("res7", result0, 4'h7);
        chk("ready1", ready0, 1'b1);
        chk("cnt1", cnt0, 16'd1);
        chk("busy_done", busy0, 1'b0);
        chk_img0("img_hold_infer", pat_a);
        img0 = '0;
        step();
        chk("ready_held", ready0, 1'b1);
        chk("res_held", result0, 4'h7);
        chk_img0("img_hold_done", pat_a);
        clr0 = 1'b1;
        step();
        clr0 = 1'b0;
        chk("clr_ready", ready0, 1'b0);
        chk("clr_res_keep", result0, 4'h7);
        chk("clr_terr", terr0, 1'b0);

        // Watchdog (or indefinite wait when it is not built).
        start0_pulse({pat_b, 4'hC});
        chk("busy_wd", busy0, 1'b1);
        chk_img0("img_b", pat_b);
`ifdef BNN_IF_TIMEOUT_EN
        repeat (7) step();
        chk("wd_not_yet", ready0, 1'b0);
        chk("wd_busy7", busy0, 1'b1);
        step();
        chk("wd_res", result0, 4'hF);
        chk("wd_ready", ready0, 1'b1);
        chk("wd_terr", terr0, 1'b1);
        chk("wd_cnt", cnt0, 16'd1);
        chk("wd_busy", busy0, 1'b0);
        clr0 = 1'b1;
        step();
        clr0 = 1'b0;
        chk("wd_clr_terr", terr0, 1'b0);
        chk("wd_clr_ready", ready0, 1'b0);
        chk("wd_clr_res", result0, 4'hF);
`else
        repeat (20) step();
        chk("nowd_ready", ready0, 1'b0);
        chk("nowd_terr", terr0, 1'b0);
        chk("nowd_busy", busy0, 1'b1);
        clr0 = 1'b1;
        step();
        clr0 = 1'b0;
        chk("nowd_abort_busy", busy0, 1'b0);
        chk("nowd_abort_ready", ready0, 1'b0);
        chk("nowd_abort_cnt", cnt0, 16'd1);
`endif

        // core_done and bnn_clear together: done wins.
        start0_pulse({pat_a, 4'h0});
        done0 = 1'b1;
        res0  = 4'h3;
        clr0  = 1'b1;
        step();
        done0 = 1'b0;
        chk("co_ready", ready0, 1'b1);
        chk("co_res", result0, 4'h3);
        chk("co_cnt", cnt0, 16'd2);
        chk("co_busy", busy0, 1'b0);
        step();
        clr0 = 1'b0;
        chk("co_clr_ready", ready0, 1'b0);
        chk("co_clr_res", result0, 4'h3);

        // Abort in INFER.
        start0_pulse({pat_b, 4'h0});
        chk("ab_busy", busy0, 1'b1);
        clr0 = 1'b1;
        step();
        clr0 = 1'b0;
        chk("ab_busy_lo", busy0, 1'b0);
        chk("ab_ready", ready0, 1'b0);
        chk("ab_cnt", cnt0, 16'd2);
        chk("ab_res", result0, 4'h3);
        step();
        chk("ab_ready2", ready0, 1'b0);

        // Asynchronous reset mid-INFER, then a stale core_done.
        start0_pulse({pat_a, 4'h0});
        chk("ar_busy", busy0, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        chk("ar_busy0", busy0, 1'b0);
        chk("ar_cnt0", cnt0, 16'd0);
        chk("ar_res0", result0, 4'h0);
        chk("ar_ready0", ready0, 1'b0);
        chk("ar_start0", start0, 1'b0);
        chk("ar_terr0", terr0, 1'b0);
        chk_img0("ar_img0", '0);
        step();
        rst   = 1'b0;
        done0 = 1'b1;
        res0  = 4'h9;
        step();
        done0 = 1'b0;
        chk("stale_ready", ready0, 1'b0);
        chk("stale_cnt", cnt0, 16'd0);
        chk("stale_res", result0, 4'h0);
        chk("stale_busy", busy0, 1'b0);

        // Two-channel instance, back-to-back inferences with 2-bit wrap.
        for (int i = 0; i < 5; i++) begin
            v     = vecs[i];
            img1  = v;
            full1 = 1'b1;
            en1   = 1'b1;
            step();
            full1 = 1'b0;
            en1   = 1'b0;
            chk("b2b_img", core_img1, v[35:4]);
            chk("b2b_start", start1, 1'b1);
            done1 = 1'b1;
            res1  = 4'(i + 1);
            step();
            done1 = 1'b0;
            chk("b2b_cnt", cnt1, ecnt[i]);
            chk("b2b_res", result1, 4'(i + 1));
            chk("b2b_ready", ready1, 1'b1);
            clr1 = 1'b1;
            step();
            clr1 = 1'b0;
            chk("b2b_clr", ready1, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
